// File: rtl/aoi_exp_stream.sv
// Streaming AND-OR-INVERT with expander. Each accepted beat contributes Groups AND-terms of
// TermW inputs plus one expander pair; results are ORed across a frame of up to MaxBeats
// beats and presented, registered, on frame close until the consumer takes them.
module aoi_exp_stream #(
    parameter int unsigned Groups   = 4,
    parameter int unsigned TermW    = 2,
    parameter int unsigned MaxBeats = 4,
    localparam int unsigned CntW    = $clog2(MaxBeats + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [Groups*TermW-1:0] in_data_i,
    input  logic                    in_x_i,
    input  logic                    in_xbar_i,
    input  logic                    in_last_i,
    input  logic                    mode_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    y_o,
    output logic [Groups-1:0]       y_terms_o,
    output logic [CntW-1:0]         beat_cnt_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e            state_q, state_d;
    logic              acc_q;
    logic [Groups-1:0] hits_q;
    logic [CntW-1:0]   cnt_q;
    logic              mode_q;
    logic              y_q;
    logic [Groups-1:0] terms_q;
    logic [CntW-1:0]   bcnt_q;
    logic              err_q;

    logic              ready;
    logic              accept;
    logic              first;
    logic              close;
    logic [Groups-1:0] terms;
    logic              beat_or;
    logic              acc_new;
    logic [Groups-1:0] hits_new;
    logic [CntW-1:0]   cnt_new;
    logic              mode_new;

    // Per-beat term evaluation and the frame accumulator's next values.
    always_comb begin
        terms = '0;
        for (int g = 0; g < int'(Groups); g++) begin
            terms[g] = &in_data_i[g*TermW +: TermW];
        end
        beat_or  = (|terms) | in_x_i | ~in_xbar_i;
        ready    = (state_q != StHold);
        accept   = in_valid_i & ready;
        first    = (state_q == StIdle);
        // The first beat of a frame starts from a clean accumulator.
        acc_new  = (first ? 1'b0 : acc_q) | beat_or;
        hits_new = (first ? '0 : hits_q) | terms;
        cnt_new  = (first ? '0 : cnt_q) + 1'b1;
        mode_new = first ? mode_i : mode_q;
        close    = accept & (in_last_i | (cnt_new == CntW'(MaxBeats)));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = close ? StHold : StAccum;
            StAccum: if (close) state_d = StHold;
            StHold:  if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Frame accumulator and registered result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= 1'b0;
            hits_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            y_q     <= 1'b0;
            terms_q <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            acc_q  <= acc_new;
            hits_q <= hits_new;
            cnt_q  <= cnt_new;
            mode_q <= mode_new;
            if (close) begin
                y_q     <= mode_new ? acc_new : ~acc_new;
                terms_q <= hits_new;
                bcnt_q  <= cnt_new;
                err_q   <= ~in_last_i;
            end
        end else if ((state_q == StHold) && out_ready_i) begin
            acc_q   <= 1'b0;
            hits_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            y_q     <= 1'b0;
            terms_q <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end
    end

    // Outputs: result fields are forced to zero whenever no result is presented.
    always_comb begin
        in_ready_o  = ready;
        out_valid_o = (state_q == StHold);
        y_o         = out_valid_o ? y_q : 1'b0;
        y_terms_o   = out_valid_o ? terms_q : '0;
        beat_cnt_o  = out_valid_o ? bcnt_q : '0;
        err_o       = out_valid_o ? err_q : 1'b0;
    end

endmodule

// File: tb/tb_aoi_exp_stream.sv
// Bench for aoi_exp_stream: directed frames with literal expectations, plus a frame-level
// reference model compared against the DUT on every cycle.
module tb_aoi_exp_stream;

    localparam int G = 4;
    localparam int W = 2;
    localparam int M = 4;
    localparam int C = $clog2(M + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [G*W-1:0] in_data = '0;
    logic           in_x = 1'b0;
    logic           in_xbar = 1'b1;
    logic           in_last = 1'b0;
    logic           mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           y;
    logic [G-1:0]   y_terms;
    logic [C-1:0]   beat_cnt;
    logic           err;

    int tests = 0;
    int fails = 0;

    aoi_exp_stream #(.Groups(G), .TermW(W), .MaxBeats(M)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_x_i     (in_x),
        .in_xbar_i  (in_xbar),
        .in_last_i  (in_last),
        .mode_i     (mode),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .y_o        (y),
        .y_terms_o  (y_terms),
        .beat_cnt_o (beat_cnt),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Reference model: collect the beats of a frame, evaluate the whole frame when it closes.
    typedef struct packed {
        logic [G*W-1:0] data;
        logic           x;
        logic           xbar;
    } beat_t;

    beat_t        frame[$];
    logic         f_mode;
    logic         e_valid = 1'b0;
    logic         e_y = 1'b0;
    logic [G-1:0] e_terms = '0;
    int           e_cnt = 0;
    logic         e_err = 1'b0;
    logic         sim_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            frame.delete();
            e_valid = 1'b0;
            e_y = 1'b0; e_terms = '0; e_cnt = 0; e_err = 1'b0;
        end else if (e_valid) begin
            if (out_ready) begin
                e_valid = 1'b0;
                e_y = 1'b0; e_terms = '0; e_cnt = 0; e_err = 1'b0;
            end
        end else if (in_valid) begin
            beat_t b;
            b.data = in_data; b.x = in_x; b.xbar = in_xbar;
            frame.push_back(b);
            if (frame.size() == 1) f_mode = mode;
            if (in_last || frame.size() == M) begin
                logic any;
                any = 1'b0;
                e_terms = '0;
                foreach (frame[i]) begin
                    for (int g = 0; g < G; g++) begin
                        int ones;
                        ones = 0;
                        for (int k = 0; k < W; k++) ones += int'(frame[i].data[g*W+k]);
                        if (ones == W) e_terms[g] = 1'b1;
                    end
                    if (frame[i].x || !frame[i].xbar) any = 1'b1;
                end
                if (e_terms != 0) any = 1'b1;
                e_y     = f_mode ? any : !any;
                e_cnt   = frame.size();
                e_err   = !in_last;
                e_valid = 1'b1;
                frame.delete();
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (sim_on) begin
            tests++;
            if (out_valid !== e_valid || in_ready !== !e_valid || y !== e_y
                || y_terms !== e_terms || int'(beat_cnt) != e_cnt || err !== e_err) begin
                fails++;
                $display("FAIL model t=%0t got v=%b r=%b y=%b terms=%b cnt=%0d err=%b want v=%b r=%b y=%b terms=%b cnt=%0d err=%b",
                         $time, out_valid, in_ready, y, y_terms, beat_cnt, err,
                         e_valid, !e_valid, e_y, e_terms, e_cnt, e_err);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string name, input int ey, input int et, input int ec,
                             input int ee);
        check({name, ".valid"}, int'(out_valid), 1);
        check({name, ".y"}, int'(y), ey);
        check({name, ".terms"}, int'(y_terms), et);
        check({name, ".cnt"}, int'(beat_cnt), ec);
        check({name, ".err"}, int'(err), ee);
    endtask

    // One accepted beat; caller guarantees the block is ready.
    task automatic send(input logic [G*W-1:0] d, input logic x, input logic xb,
                        input logic last, input logic md);
        in_valid = 1'b1; in_data = d; in_x = x; in_xbar = xb; in_last = last; mode = md;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sim_on = 1'b1;
        check("reset.valid", int'(out_valid), 0);
        check("reset.ready", int'(in_ready), 1);

        // 1: single group hit.
        send(8'b00_00_11_00, 0, 1, 1, 0);
        check_res("t1", 0, 4'b0010, 1, 0);
        take();
        check("t1.idle", int'(out_valid), 0);

        // 2: no terms hit, both modes.
        send(8'b10_01_10_01, 0, 1, 1, 0);
        check_res("t2a", 1, 0, 1, 0);
        take();
        send(8'b10_01_10_01, 0, 1, 1, 1);
        check_res("t2b", 0, 0, 1, 0);
        take();

        // 3: expander XBAR=0 on the last beat; MODE change mid-frame is ignored.
        send(8'h00, 0, 1, 0, 0);
        send(8'h00, 0, 1, 0, 1);
        send(8'h00, 0, 0, 1, 1);
        check_res("t3", 0, 0, 3, 0);
        take();

        // 4: forced close at MaxBeats, then the same with LAST on the final beat.
        for (int rep = 0; rep < 2; rep++) begin
            send(8'h00, 0, 1, 0, 0);
            send(8'b11_00_00_00, 0, 1, 0, 0);
            send(8'h00, 0, 1, 0, 0);
            send(8'h00, 0, 1, logic'(rep), 0);
            check_res(rep == 0 ? "t4a" : "t4b", 0, 4'b1000, 4, rep == 0 ? 1 : 0);
            take();
        end

        // 5: backpressure in HOLD with a beat waiting.
        send(8'b00_00_11_00, 0, 1, 1, 0);
        in_valid = 1'b1; in_data = 8'b10_01_10_01; in_x = 0; in_xbar = 1; in_last = 1;
        mode = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5.ready", int'(in_ready), 0);
            check_res("t5.hold", 0, 4'b0010, 1, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t5.idle_valid", int'(out_valid), 0);
        check("t5.idle_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check_res("t5.next", 1, 0, 1, 0);
        take();

        // 6: reset mid-frame drops the partial frame.
        send(8'b11_11_11_11, 1, 0, 0, 1);
        send(8'b11_11_11_11, 1, 0, 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6.valid", int'(out_valid), 0);
        check("t6.ready", int'(in_ready), 1);
        check("t6.y", int'(y), 0);
        check("t6.terms", int'(y_terms), 0);
        check("t6.cnt", int'(beat_cnt), 0);
        send(8'b10_01_10_01, 0, 1, 1, 0);
        check_res("t6.new", 1, 0, 1, 0);
        take();

        @(posedge clk); #1;
        sim_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
